// File: rtl/inst_axi_rbridge.sv
// Instruction-fetch bridge: SRAM-like request port to AXI AR/R, in-order, single ARID.
// Optional flush cancellation of in-flight reads is built when INST_BRIDGE_CANCEL_EN is defined.
module inst_axi_rbridge #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned CNT_W       = 3,
    parameter logic [3:0]  ARID_VAL    = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        flush,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(OUTSTANDING);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             addr_ok;
    logic             r_fire;

    // Write-side inputs and R-channel id/resp carry no information for a fetch port.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp};

    assign arid    = ARID_VAL;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = 1'b1;

    assign r_fire  = rvalid & rlast;
    assign addr_ok = ~reset & inst_sram_req & ~arvalid & (in_cnt_q < MaxCnt) & ~flush;

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_rdata   = rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            arsize  <= 3'd0;
        end else if (addr_ok) begin
            arvalid <= 1'b1;
            araddr  <= inst_sram_addr;
            arsize  <= {1'b0, inst_sram_size};
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_comb begin
        in_cnt_d = in_cnt_q;
        unique case ({addr_ok, r_fire})
            2'b10:   in_cnt_d = in_cnt_q + One;
            2'b01:   in_cnt_d = (in_cnt_q == '0) ? '0 : in_cnt_q - One;
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt_q <= '0;
        end else begin
            in_cnt_q <= in_cnt_d;
        end
    end

`ifdef INST_BRIDGE_CANCEL_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Flush discards everything still in flight; a beat landing in the flush cycle is one of them.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            if (r_fire) begin
                drop_cnt_d = (in_cnt_q == '0) ? '0 : in_cnt_q - One;
            end else begin
                drop_cnt_d = in_cnt_q;
            end
        end else if (r_fire && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - One;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign inst_sram_data_ok = ~reset & r_fire & (drop_cnt_q == '0) & ~flush;
`else
    assign inst_sram_data_ok = ~reset & r_fire;
`endif

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Directed bench for inst_axi_rbridge; flush expectations follow INST_BRIDGE_CANCEL_EN.
module tb_inst_axi_rbridge;

    logic        clk;
    logic        reset;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] sram_rdata;
    logic        flush;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;
    int model_cnt;

`ifdef INST_BRIDGE_CANCEL_EN
    localparam logic DropOk = 1'b0;
`else
    localparam logic DropOk = 1'b1;
`endif

    inst_axi_rbridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (req),
        .inst_sram_wr      (1'b0),
        .inst_sram_size    (size),
        .inst_sram_wstrb   (4'h0),
        .inst_sram_addr    (addr),
        .inst_sram_wdata   (32'd0),
        .inst_sram_addr_ok (addr_ok),
        .inst_sram_data_ok (data_ok),
        .inst_sram_rdata   (sram_rdata),
        .flush             (flush),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (4'd0),
        .rdata             (rdata),
        .rresp             (2'b00),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reads the bench has had accepted; an R beat with none outstanding is a slave-side bug.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_cnt <= 0;
        end else begin
            if (rvalid && rlast && model_cnt == 0) $error("protocol violation: R beat with no read in flight");
            model_cnt <= model_cnt + (addr_ok ? 1 : 0) - ((rvalid && rlast) ? 1 : 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic [31:0] a);
        req  = r;
        addr = a;
    endtask

    task automatic set_r(input logic v, input logic [31:0] d);
        rvalid = v;
        rlast  = v;
        rdata  = d;
    endtask

    initial begin
        reset = 1'b1;
        size = 2'h2;
        flush = 1'b0;
        arready = 1'b1;
        set_req(1'b1, 32'hbfc0_0000);
        set_r(1'b1, 32'h1234_5678);
        #6;
        check_eq("rst_addr_ok", addr_ok, 0);
        check_eq("rst_data_ok", data_ok, 0);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_araddr", araddr, 0);
        check_eq("rst_arsize", arsize, 0);
        check_eq("const_ar", {arid, arlen, arburst, arlock, arcache, arprot, rready},
                 {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
        next_cycle();
        reset = 1'b0;
        set_r(1'b0, 32'd0);

        // Basic fetch
        set_req(1'b1, 32'hbfc0_0000);
        #1 check_eq("t1_addr_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        #1 check_eq("t1_arvalid", arvalid, 1);
        check_eq("t1_araddr", araddr, 32'hbfc0_0000);
        check_eq("t1_arsize", arsize, 3'd2);
        check_eq("t1_data_ok_early", data_ok, 0);
        next_cycle();
        set_r(1'b1, 32'h3c1d_0000);
        #1 check_eq("t1_data_ok", data_ok, 1);
        check_eq("t1_rdata", sram_rdata, 32'h3c1d_0000);
        next_cycle();
        set_r(1'b0, 32'd0);

        // AR backpressure
        arready = 1'b0;
        set_req(1'b1, 32'hbfc0_0004);
        #1 check_eq("t2_addr_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0008);
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("t2_hold_arvalid", arvalid, 1);
            check_eq("t2_hold_araddr", araddr, 32'hbfc0_0004);
            check_eq("t2_hold_addr_ok", addr_ok, 0);
            next_cycle();
        end
        arready = 1'b1;
        #1 check_eq("t2_hs_addr_ok", addr_ok, 0);
        next_cycle();
        #1 check_eq("t2_second_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        #1 check_eq("t2_araddr2", araddr, 32'hbfc0_0008);
        next_cycle();
        set_r(1'b1, 32'haaaa_0001);
        #1 check_eq("t2_data1", data_ok, 1);
        next_cycle();
        set_r(1'b1, 32'haaaa_0002);
        #1 check_eq("t2_data2", data_ok, 1);
        check_eq("t2_rdata2", sram_rdata, 32'haaaa_0002);
        next_cycle();
        set_r(1'b0, 32'd0);

        // Outstanding limit, then accept and R beat in the same cycle
        set_req(1'b1, 32'hbfc0_0100);
        #1 check_eq("t3_a_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0104);
        #1 check_eq("t3_b_blocked_ar", addr_ok, 0);
        next_cycle();
        #1 check_eq("t3_b_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0108);
        #1 check_eq("t3_c_blocked_ar", addr_ok, 0);
        next_cycle();
        #1 check_eq("t3_c_full", addr_ok, 0);
        next_cycle();
        set_r(1'b1, 32'hd000_0100);
        #1 check_eq("t3_c_no_bypass", addr_ok, 0);
        check_eq("t3_a_data", data_ok, 1);
        next_cycle();
        set_r(1'b0, 32'd0);
        #1 check_eq("t3_c_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        set_r(1'b1, 32'hd000_0104);
        #1 check_eq("t4_b_data", data_ok, 1);
        check_eq("t4_araddr_c", araddr, 32'hbfc0_0108);
        next_cycle();
        set_req(1'b1, 32'hbfc0_010c);
        set_r(1'b1, 32'hd000_0108);
        #1 check_eq("t4_same_ok", addr_ok, 1);
        check_eq("t4_same_data", data_ok, 1);
        check_eq("t4_same_rdata", sram_rdata, 32'hd000_0108);
        next_cycle();
        set_req(1'b0, 32'd0);
        set_r(1'b0, 32'd0);
        #1 check_eq("t4_araddr_d", araddr, 32'hbfc0_010c);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0110);
        #1 check_eq("t4_e_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0114);
        next_cycle();
        #1 check_eq("t4_f_full", addr_ok, 0);
        next_cycle();
        set_req(1'b0, 32'd0);
        set_r(1'b1, 32'hd000_010c);
        #1 check_eq("t4_d_data", data_ok, 1);
        next_cycle();
        set_r(1'b1, 32'hd000_0110);
        #1 check_eq("t4_e_data", data_ok, 1);
        next_cycle();
        set_r(1'b0, 32'd0);

        // Flush with two reads in flight
        set_req(1'b1, 32'hbfc0_0200);
        #1 check_eq("t5_g_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0204);
        #1 check_eq("t5_h_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        next_cycle();
        flush = 1'b1;
        set_req(1'b1, 32'hbfc0_0380);
        #1 check_eq("t5_flush_addr_ok", addr_ok, 0);
        next_cycle();
        flush = 1'b0;
        set_r(1'b1, 32'hdead_0200);
        #1 check_eq("t5_beat1", data_ok, DropOk);
        check_eq("t5_full", addr_ok, 0);
        next_cycle();
        set_r(1'b1, 32'hdead_0204);
        #1 check_eq("t5_beat2", data_ok, DropOk);
        check_eq("t5_new_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        set_r(1'b0, 32'd0);
        #1 check_eq("t5_araddr", araddr, 32'hbfc0_0380);
        next_cycle();
        set_r(1'b1, 32'h2408_0380);
        #1 check_eq("t5_beat3", data_ok, 1);
        check_eq("t5_rdata3", sram_rdata, 32'h2408_0380);
        next_cycle();
        set_r(1'b0, 32'd0);

        // Asynchronous reset mid-transaction
        set_req(1'b1, 32'hbfc0_0400);
        next_cycle();
        set_req(1'b0, 32'd0);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0404);
        next_cycle();
        arready = 1'b0;
        #1 check_eq("t6_pre_arvalid", arvalid, 1);
        #1 reset = 1'b1;
        #1 check_eq("t6_async_arvalid", arvalid, 0);
        check_eq("t6_async_araddr", araddr, 0);
        check_eq("t6_async_addr_ok", addr_ok, 0);
        next_cycle();
        reset = 1'b0;
        arready = 1'b1;
        set_req(1'b1, 32'hbfc0_0500);
        #1 check_eq("t6_post_ok", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        #1 check_eq("t6_post_araddr", araddr, 32'hbfc0_0500);
        next_cycle();
        set_req(1'b1, 32'hbfc0_0504);
        #1 check_eq("t6_cnt_cleared", addr_ok, 1);
        next_cycle();
        set_req(1'b0, 32'd0);
        next_cycle();
        set_r(1'b1, 32'h0000_0500);
        #1 check_eq("t6_data1", data_ok, 1);
        next_cycle();
        set_r(1'b1, 32'h0000_0504);
        #1 check_eq("t6_data2", data_ok, 1);
        next_cycle();
        set_r(1'b0, 32'd0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
